// File: rtl/ir_encoder_if.sv
// Handshake/bus bundle between an IR frame source and ir_encoder.
// The master drives the code and trigger; the encoder (slave) drives the envelope and status.
interface ir_encoder_if #(
  parameter int NBITS = 32
);
  logic [NBITS-1:0] code_in;
  logic             trigger_in;
  logic             signal_out;
  logic             busy_out;
  logic             done_out;
  logic [2:0]       state_out;

  modport master (
    output code_in, trigger_in,
    input  signal_out, busy_out, done_out, state_out
  );

  modport slave (
    input  code_in, trigger_in,
    output signal_out, busy_out, done_out, state_out
  );
endinterface

// File: rtl/ir_encoder.sv
// Pulse-distance IR transmitter: serialises a code MSB first as sync burst/silence,
// per-bit burst plus short/long silence, and a stop burst. Output is active-low (idle high).
module ir_encoder #(
  parameter int SBD   = 900,
  parameter int SSD   = 450,
  parameter int BBD   = 60,
  parameter int BSD0  = 60,
  parameter int BSD1  = 160,
  parameter int NBITS = 32
) (
  input  logic        clk_in,
  input  logic        rst_in,
  ir_encoder_if.slave bus
);

  localparam int MAX_AB = (SBD > SSD) ? SBD : SSD;
  localparam int MAX_CD = (BBD > BSD0) ? BBD : BSD0;
  localparam int MAX_AD = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int MAXD   = (MAX_AD > BSD1) ? MAX_AD : BSD1;
  localparam int CNT_W  = $clog2(MAXD) + 1;
  localparam int IDX_W  = $clog2(NBITS) + 1;

  if (SBD < 1 || SSD < 1 || BBD < 1 || BSD0 < 1 || BSD1 < 1) begin : g_bad_duration
    $error("ir_encoder: every duration parameter must be >= 1");
  end

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    SYNC_BURST = 3'd1,
    SYNC_SIL   = 3'd2,
    BIT_BURST  = 3'd3,
    BIT_SIL    = 3'd4,
    STOP_BURST = 3'd5
  } state_t;

  state_t             state_q, state_d;
  logic [NBITS-1:0]   shift_q, shift_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               signal_q, signal_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [CNT_W-1:0]   last_cnt;
  logic               at_end;

  // Terminal count of the current segment; the silence length depends on the bit being sent.
  always_comb begin
    last_cnt = '0;
    case (state_q)
      SYNC_BURST: last_cnt = CNT_W'(SBD - 1);
      SYNC_SIL:   last_cnt = CNT_W'(SSD - 1);
      BIT_BURST:  last_cnt = CNT_W'(BBD - 1);
      BIT_SIL:    last_cnt = shift_q[NBITS-1] ? CNT_W'(BSD1 - 1) : CNT_W'(BSD0 - 1);
      STOP_BURST: last_cnt = CNT_W'(BBD - 1);
      default:    last_cnt = '0;
    endcase
    at_end = (cnt_q == last_cnt);
  end

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q + CNT_W'(1);
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (bus.trigger_in) begin
          shift_d = bus.code_in;
          idx_d   = '0;
          state_d = SYNC_BURST;
        end
      end
      SYNC_BURST: if (at_end) state_d = SYNC_SIL;
      SYNC_SIL:   if (at_end) state_d = BIT_BURST;
      BIT_BURST:  if (at_end) state_d = BIT_SIL;
      BIT_SIL: begin
        if (at_end) begin
          shift_d = shift_q << 1;
          idx_d   = idx_q + IDX_W'(1);
          state_d = (idx_d == IDX_W'(NBITS)) ? STOP_BURST : BIT_BURST;
        end
      end
      STOP_BURST: begin
        if (at_end) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (state_d != state_q) cnt_d = '0;
    // Outputs are decoded from the next state so they leave the flops aligned with it.
    signal_d = !(state_d == SYNC_BURST || state_d == BIT_BURST || state_d == STOP_BURST);
    busy_d   = (state_d != IDLE);
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_q  <= IDLE;
      shift_q  <= '0;
      idx_q    <= '0;
      cnt_q    <= '0;
      signal_q <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      signal_q <= signal_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign bus.signal_out = signal_q;
  assign bus.busy_out   = busy_q;
  assign bus.done_out   = done_q;
  assign bus.state_out  = state_q;

endmodule
